id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection and writeback
// operand bypass.
//
// Each rising clk edge, the decode slot moves into the EX registers if it
// holds a real instruction that is neither squashed nor blocked by a
// load-use hazard. Otherwise a bubble, with every EX field zeroed, is
// inserted. The stall output is combinational and freezes PC and IF/ID in
// the same cycle that the hazard is seen.
//
// Ports
//   clk, rst                     pipeline clock, asynchronous active-high reset
//   id_valid                     decode slot holds a real instruction
//   id_pc, id_imm                decode PC, sign-extended immediate (32)
//   id_rs, id_rt, id_rd          source 1, source 2 and destination index (5)
//   id_rdata1, id_rdata2         register-file read data for id_rs / id_rt
//   id_reg_write, id_mem_read,
//   id_mem_write, id_alu_op      decode controls (alu op is 4 bits)
//   flush                        branch/jump squash of the decode slot
//   wb_enable_write,
//   wb_write_reg, wb_write_data  writeback port, used here for bypass
//   stall                        hold PC and IF/ID (combinational)
//   ex_*                         registered EX-stage copy of the decode slot
//   stall_count                  saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [31:0] id_rdata1,
   input  logic [31:0] id_rdata2,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic [3:0]  id_alu_op,
   input  logic        flush,
   input  logic        wb_enable_write,
   input  logic [4:0]  wb_write_reg,
   input  logic [31:0] wb_write_data,
   output logic        stall,
   output logic        ex_valid,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic [3:0]  ex_alu_op,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_imm,
   output logic [31:0] ex_op1,
   output logic [31:0] ex_op2,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_rd,
   output logic [15:0] stall_count
);

   // Operand selection: register 0 always reads as zero; otherwise a
   // same-cycle writeback to the source index wins over the stale
   // register-file data. A nonzero idx matching wb_reg implies wb_reg != 0.
   function automatic logic [31:0] pick_operand(
      input logic [4:0]  idx,
      input logic [31:0] rdata,
      input logic        wb_en,
      input logic [4:0]  wb_reg,
      input logic [31:0] wb_data
   );
      logic [31:0] val;
      if (idx == 5'd0) begin
         val = 32'd0;
      end else if (wb_en && (wb_reg == idx)) begin
         val = wb_data;
      end else begin
         val = rdata;
      end
      return val;
   endfunction

   logic        hazard_s;
   logic        stall_s;
   logic        capture_s;
   logic [31:0] op1_s;
   logic [31:0] op2_s;

   logic        ex_valid_r;
   logic        ex_reg_write_r;
   logic        ex_mem_read_r;
   logic        ex_mem_write_r;
   logic [3:0]  ex_alu_op_r;
   logic [31:0] ex_pc_r;
   logic [31:0] ex_imm_r;
   logic [31:0] ex_op1_r;
   logic [31:0] ex_op2_r;
   logic [4:0]  ex_rs_r;
   logic [4:0]  ex_rt_r;
   logic [4:0]  ex_rd_r;
   logic [15:0] stall_count_r;

   // Hazard detection and capture decision; flush overrides hazard.
   always_comb begin
      hazard_s  = id_valid & ex_valid_r & ex_mem_read_r & (ex_rd_r != 5'd0) &
                  ((ex_rd_r == id_rs) | (ex_rd_r == id_rt));
      stall_s   = hazard_s & ~flush;
      capture_s = id_valid & ~flush & ~hazard_s;
   end

   // Bypassed operand values for the instruction being captured.
   always_comb begin
      op1_s = pick_operand(id_rs, id_rdata1, wb_enable_write, wb_write_reg, wb_write_data);
      op2_s = pick_operand(id_rt, id_rdata2, wb_enable_write, wb_write_reg, wb_write_data);
   end

   // ID/EX pipeline register: load the decode slot or insert an all-zero
   // bubble. A bubble clears ex_mem_read, so a load-use stall lasts one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_r     <= 1'b0;
         ex_reg_write_r <= 1'b0;
         ex_mem_read_r  <= 1'b0;
         ex_mem_write_r <= 1'b0;
         ex_alu_op_r    <= 4'd0;
         ex_pc_r        <= 32'd0;
         ex_imm_r       <= 32'd0;
         ex_op1_r       <= 32'd0;
         ex_op2_r       <= 32'd0;
         ex_rs_r        <= 5'd0;
         ex_rt_r        <= 5'd0;
         ex_rd_r        <= 5'd0;
      end else if (capture_s) begin
         ex_valid_r     <= 1'b1;
         ex_reg_write_r <= id_reg_write;
         ex_mem_read_r  <= id_mem_read;
         ex_mem_write_r <= id_mem_write;
         ex_alu_op_r    <= id_alu_op;
         ex_pc_r        <= id_pc;
         ex_imm_r       <= id_imm;
         ex_op1_r       <= op1_s;
         ex_op2_r       <= op2_s;
         ex_rs_r        <= id_rs;
         ex_rt_r        <= id_rt;
         ex_rd_r        <= id_rd;
      end else begin
         ex_valid_r     <= 1'b0;
         ex_reg_write_r <= 1'b0;
         ex_mem_read_r  <= 1'b0;
         ex_mem_write_r <= 1'b0;
         ex_alu_op_r    <= 4'd0;
         ex_pc_r        <= 32'd0;
         ex_imm_r       <= 32'd0;
         ex_op1_r       <= 32'd0;
         ex_op2_r       <= 32'd0;
         ex_rs_r        <= 5'd0;
         ex_rt_r        <= 5'd0;
         ex_rd_r        <= 5'd0;
      end
   end

   // Saturating count of load-use bubbles (squashed hazards do not count).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count_r <= 16'd0;
      end else if (stall_s && (stall_count_r != 16'hFFFF)) begin
         stall_count_r <= stall_count_r + 16'd1;
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   assign stall        = stall_s;
   assign ex_valid     = ex_valid_r;
   assign ex_reg_write = ex_reg_write_r;
   assign ex_mem_read  = ex_mem_read_r;
   assign ex_mem_write = ex_mem_write_r;
   assign ex_alu_op    = ex_alu_op_r;
   assign ex_pc        = ex_pc_r;
   assign ex_imm       = ex_imm_r;
   assign ex_op1       = ex_op1_r;
   assign ex_op2       = ex_op2_r;
   assign ex_rs        = ex_rs_r;
   assign ex_rt        = ex_rt_r;
   assign ex_rd        = ex_rd_r;
   assign stall_count  = stall_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed-vector bench for id_ex_stage. Inputs are driven on the falling
// edge and outputs are sampled on the following falling edge (registered
// fields) or 1 ns after driving (combinational stall).
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_imm;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [31:0] id_rdata1;
   logic [31:0] id_rdata2;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_write;
   logic [3:0]  id_alu_op;
   logic        flush;
   logic        wb_enable_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic        stall;
   logic        ex_valid;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [3:0]  ex_alu_op;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [31:0] ex_op1;
   logic [31:0] ex_op2;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic [4:0]  ex_rd;
   logic [15:0] stall_count;

   int          vec_cnt;
   int          err_cnt;
   logic [15:0] exp_cnt;

   id_ex_stage dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
      .flush(flush),
      .wb_enable_write(wb_enable_write), .wb_write_reg(wb_write_reg),
      .wb_write_data(wb_write_data),
      .stall(stall),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_alu_op(ex_alu_op), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .stall_count(stall_count)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      id_valid        = 1'b0;
      id_pc           = 32'd0;
      id_imm          = 32'd0;
      id_rs           = 5'd0;
      id_rt           = 5'd0;
      id_rd           = 5'd0;
      id_rdata1       = 32'd0;
      id_rdata2       = 32'd0;
      id_reg_write    = 1'b0;
      id_mem_read     = 1'b0;
      id_mem_write    = 1'b0;
      id_alu_op       = 4'd0;
      flush           = 1'b0;
      wb_enable_write = 1'b0;
      wb_write_reg    = 5'd0;
      wb_write_data   = 32'd0;
   endtask

   task automatic check_bubble(input string tag);
      check_val({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
      check_val({tag, "_ctl"}, {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op[1:0]}, 32'd0);
      check_val({tag, "_alu"}, {28'd0, ex_alu_op}, 32'd0);
      check_val({tag, "_pc"}, ex_pc, 32'd0);
      check_val({tag, "_imm"}, ex_imm, 32'd0);
      check_val({tag, "_op1"}, ex_op1, 32'd0);
      check_val({tag, "_op2"}, ex_op2, 32'd0);
      check_val({tag, "_idx"}, {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
   endtask

   // Load into EX writing rd, then a consumer of rd: expect one stall cycle
   // and a bubble. Leaves the consumer on the ID inputs.
   task automatic load_use(input logic [4:0] rd, input string tag);
      idle_inputs();
      id_valid    = 1'b1;
      id_rs       = 5'd1;
      id_rt       = 5'd2;
      id_rd       = rd;
      id_mem_read = 1'b1;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      id_valid = 1'b1;
      id_rs    = rd;
      id_rt    = 5'd3;
      id_rd    = 5'd4;
      #1;
      check_val({tag, "_stall"}, {31'd0, stall}, 32'd1);
      exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
      @(posedge clk);
      @(negedge clk);
      check_val({tag, "_cnt"}, {16'd0, stall_count}, {16'd0, exp_cnt});
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      exp_cnt = 16'd0;
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      check_bubble("rst");
      check_val("rst_cnt", {16'd0, stall_count}, 32'd0);
      check_val("rst_stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;

      // Basic capture
      id_valid = 1'b1; id_rs = 5'd19; id_rt = 5'd20; id_rd = 5'd7;
      id_rdata1 = 32'd5; id_rdata2 = 32'd15; id_alu_op = 4'h2;
      id_pc = 32'h0000_0100; id_imm = 32'hFFFF_FFF0;
      id_reg_write = 1'b1; id_mem_write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("cap_op1", ex_op1, 32'd5);
      check_val("cap_op2", ex_op2, 32'd15);
      check_val("cap_alu", {28'd0, ex_alu_op}, 32'd2);
      check_val("cap_valid", {31'd0, ex_valid}, 32'd1);
      check_val("cap_pc", ex_pc, 32'h0000_0100);
      check_val("cap_imm", ex_imm, 32'hFFFF_FFF0);
      check_val("cap_idx", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, 5'd19, 5'd20, 5'd7});
      check_val("cap_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'b101);

      // Writeback bypass on rt only
      wb_enable_write = 1'b1; wb_write_reg = 5'd20; wb_write_data = 32'h40;
      @(posedge clk);
      @(negedge clk);
      check_val("byp_op2", ex_op2, 32'h40);
      check_val("byp_op1_keep", ex_op1, 32'd5);

      // Writeback to register 0 never bypasses
      wb_write_reg = 5'd0;
      @(posedge clk);
      @(negedge clk);
      check_val("byp_r0_op2", ex_op2, 32'd15);

      // Both operands bypass in one cycle
      id_rs = 5'd19; id_rt = 5'd19; wb_write_reg = 5'd19; wb_write_data = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      check_val("byp2_op1", ex_op1, 32'h1234_5678);
      check_val("byp2_op2", ex_op2, 32'h1234_5678);

      // Index 0 reads as zero regardless of data or bypass
      id_rs = 5'd0; id_rt = 5'd0; id_rdata1 = 32'hDEAD; id_rdata2 = 32'hBEEF;
      wb_write_reg = 5'd0; wb_write_data = 32'h55;
      @(posedge clk);
      @(negedge clk);
      check_val("r0_op1", ex_op1, 32'd0);
      check_val("r0_op2", ex_op2, 32'd0);

      // Invalid slot gives a bubble even with nonzero fields
      id_valid = 1'b0; id_rs = 5'd3; id_rdata1 = 32'hAAAA;
      @(posedge clk);
      @(negedge clk);
      check_bubble("inv");

      // Plain flush gives a bubble
      idle_inputs();
      id_valid = 1'b1; id_rs = 5'd5; id_rdata1 = 32'h77; id_pc = 32'h200; flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_bubble("flush");

      // Load-use hazard on rs: stall, bubble, then capture proceeds
      load_use(5'd21, "lu1");
      check_bubble("lu1_bub");
      check_val("lu1_stall_clr", {31'd0, stall}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_val("lu1_after_valid", {31'd0, ex_valid}, 32'd1);
      check_val("lu1_after_rs", {27'd0, ex_rs}, 32'd21);

      // Load-use hazard on rt
      idle_inputs();
      id_valid = 1'b1; id_rd = 5'd9; id_mem_read = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd9;
      #1;
      check_val("lu_rt_stall", {31'd0, stall}, 32'd1);
      exp_cnt = exp_cnt + 16'd1;
      @(posedge clk);
      @(negedge clk);
      check_val("lu_rt_cnt", {16'd0, stall_count}, {16'd0, exp_cnt});

      // Load to register 0 is never a hazard
      idle_inputs();
      id_valid = 1'b1; id_rd = 5'd0; id_mem_read = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
      #1;
      check_val("lu_r0_stall", {31'd0, stall}, 32'd0);

      // Hazard plus flush: no stall, bubble, count unchanged
      idle_inputs();
      id_valid = 1'b1; id_rd = 5'd12; id_mem_read = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      id_valid = 1'b1; id_rs = 5'd12; id_rdata1 = 32'h99; flush = 1'b1;
      #1;
      check_val("hf_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_bubble("hf");
      check_val("hf_cnt", {16'd0, stall_count}, {16'd0, exp_cnt});

      // Saturation: preload the counter near the top, then stall past it
      force dut.stall_count_r = 16'hFFFD;
      #1;
      release dut.stall_count_r;
      exp_cnt = 16'hFFFD;
      load_use(5'd6, "sat1");
      load_use(5'd7, "sat2");
      load_use(5'd8, "sat3");
      load_use(5'd9, "sat4");

      // Reset asserted mid-cycle while a stall is pending
      idle_inputs();
      id_valid = 1'b1; id_rd = 5'd14; id_mem_read = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
      id_pc = 32'h300;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      id_valid = 1'b1; id_rs = 5'd14; id_rt = 5'd15; id_rdata2 = 32'h66; id_pc = 32'h304;
      #1;
      check_val("mr_pre_stall", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #2;
      // The bubble for the hazard landed; now let a real instruction in
      // EX and reset before the next edge.
      @(negedge clk);
      @(posedge clk);
      #2;
      check_val("mr_pre_valid", {31'd0, ex_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check_bubble("mr");
      check_val("mr_cnt", {16'd0, stall_count}, 32'd0);
      check_val("mr_stall", {31'd0, stall}, 32'd0);

      // First edge after reset performs a normal capture
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("post_rst_valid", {31'd0, ex_valid}, 32'd1);
      check_val("post_rst_op2", ex_op2, 32'h66);
      check_val("post_rst_pc", ex_pc, 32'h304);
      check_val("post_rst_cnt", {16'd0, stall_count}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
